// File: rtl/jtag_data_registers.sv
// JTAG instruction register plus the three data registers behind it
// (BYPASS, IDCODE, USER). It is driven by TAP phase levels from an
// external TAP controller. Everything is clocked on the rising edge of clk.
//
// Ports:
//   clk, reset            block clock; synchronous active-high reset
//   tdi                   serial test data in
//   captureIR, shiftIR    IR phase levels
//   captureDR, shiftDR    DR phase levels
//   updateIR, updateDR    update levels; only the rising edge acts
//   user_dr_in            parallel value captured into the USER chain
//   tdo, tdo_en           serial data out and its drive enable
//   ir_value              current (already updated) instruction
//   user_dr_out           updated USER register
//   user_upd              one-cycle pulse when user_dr_out is loaded
module jtag_data_registers #(
  parameter int              IR_W       = 4,
  parameter int              USER_W     = 8,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'h1),
  parameter logic [IR_W-1:0] OP_USER    = IR_W'(4'h2),
  parameter logic [IR_W-1:0] OP_BYPASS  = IR_W'(4'hF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tdi,
  input  logic              captureIR,
  input  logic              shiftIR,
  input  logic              captureDR,
  input  logic              shiftDR,
  input  logic              updateIR,
  input  logic              updateDR,
  input  logic [USER_W-1:0] user_dr_in,
  output logic              tdo,
  output logic              tdo_en,
  output logic [IR_W-1:0]   ir_value,
  output logic [USER_W-1:0] user_dr_out,
  output logic              user_upd
);

  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_USR} dr_sel_e;

  logic [IR_W-1:0]   ir_shift;
  logic              byp;
  logic [31:0]       id_shift;
  logic [USER_W-1:0] usr_shift;
  logic              upd_ir_q, upd_dr_q;
  dr_sel_e           sel;
  logic              ir_phase, dr_cap, dr_shf;

  // OP_BYPASS falls into the default arm along with every unassigned code.
  always_comb begin
    if (ir_value == OP_IDCODE)    sel = SEL_ID;
    else if (ir_value == OP_USER) sel = SEL_USR;
    else                          sel = SEL_BYP;
  end

  // IR activity blocks the DR chains. Capture takes precedence over shift.
  assign ir_phase = captureIR | shiftIR;
  assign dr_cap   = captureDR & ~ir_phase;
  assign dr_shf   = shiftDR & ~captureDR & ~ir_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_shift    <= '0;
      ir_value    <= OP_IDCODE;
      byp         <= 1'b0;
      id_shift    <= IDCODE_VAL;
      usr_shift   <= '0;
      user_dr_out <= '0;
      user_upd    <= 1'b0;
      upd_ir_q    <= 1'b0;
      upd_dr_q    <= 1'b0;
    end else begin
      // The edge-detect flops are cleared by reset. An update level that is
      // already high when reset drops is therefore seen as a fresh edge.
      upd_ir_q <= updateIR;
      upd_dr_q <= updateDR;
      user_upd <= 1'b0;

      if (captureIR)    ir_shift <= IR_W'(2'b01);
      else if (shiftIR) ir_shift <= {tdi, ir_shift[IR_W-1:1]};

      if (updateIR && !upd_ir_q) ir_value <= ir_shift;

      // sel comes from the pre-edge ir_value. A new instruction therefore
      // takes effect on the following cycle, and DR contents stay untouched.
      if (dr_cap) begin
        case (sel)
          SEL_ID:  id_shift  <= IDCODE_VAL;
          SEL_USR: usr_shift <= user_dr_in;
          default: byp       <= 1'b0;
        endcase
      end else if (dr_shf) begin
        case (sel)
          SEL_ID:  id_shift  <= {tdi, id_shift[31:1]};
          SEL_USR: usr_shift <= {tdi, usr_shift[USER_W-1:1]};
          default: byp       <= tdi;
        endcase
      end

      if (updateDR && !upd_dr_q && sel == SEL_USR) begin
        user_dr_out <= usr_shift;
        user_upd    <= 1'b1;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shiftIR) tdo = ir_shift[0];
    else if (shiftDR) begin
      case (sel)
        SEL_ID:  tdo = id_shift[0];
        SEL_USR: tdo = usr_shift[0];
        default: tdo = byp;
      endcase
    end
  end

  assign tdo_en = shiftIR | shiftDR;

endmodule

// File: tb/tb_jtag_data_registers.sv
module tb_jtag_data_registers;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic       clk = 1'b0;
  logic       reset, tdi, captureIR, shiftIR, captureDR, shiftDR, updateIR, updateDR;
  logic [7:0] user_dr_in;
  logic       tdo, tdo_en, user_upd;
  logic [3:0] ir_value;
  logic [7:0] user_dr_out;

  jtag_data_registers dut (
    .clk(clk), .reset(reset), .tdi(tdi),
    .captureIR(captureIR), .shiftIR(shiftIR), .captureDR(captureDR), .shiftDR(shiftDR),
    .updateIR(updateIR), .updateDR(updateDR), .user_dr_in(user_dr_in),
    .tdo(tdo), .tdo_en(tdo_en), .ir_value(ir_value),
    .user_dr_out(user_dr_out), .user_upd(user_upd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: a value per register, plus the last seen update levels.
  bit         m_valid = 1'b0;
  logic [3:0] m_irs, m_irv;
  logic       m_byp, m_upd, m_pir, m_pdr;
  logic [31:0] m_id;
  logic [7:0] m_usr, m_udo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = bypass, 1 = idcode, 2 = user
  function automatic int m_sel();
    if (m_irv == 4'h1) return 1;
    if (m_irv == 4'h2) return 2;
    return 0;
  endfunction

  function automatic logic m_tdo();
    if (shiftIR) return m_irs[0];
    if (shiftDR) begin
      case (m_sel())
        1:       return m_id[0];
        2:       return m_usr[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  task automatic model_update();
    logic [3:0]  n_irs, n_irv;
    logic        n_byp, n_upd;
    logic [31:0] n_id;
    logic [7:0]  n_usr, n_udo;
    if (reset) begin
      m_valid = 1'b1; m_irs = 0; m_irv = 4'h1; m_byp = 0; m_id = IDV;
      m_usr = 0; m_udo = 0; m_upd = 0; m_pir = 0; m_pdr = 0;
      return;
    end
    n_irs = m_irs; n_irv = m_irv; n_byp = m_byp; n_id = m_id;
    n_usr = m_usr; n_udo = m_udo; n_upd = 1'b0;
    if (captureIR)    n_irs = 4'd1;
    else if (shiftIR) n_irs = (m_irs >> 1) + (tdi ? 4'd8 : 4'd0);
    if (updateIR && !m_pir) n_irv = m_irs;
    if (!(captureIR || shiftIR)) begin
      if (captureDR) begin
        case (m_sel())
          1:       n_id  = IDV;
          2:       n_usr = user_dr_in;
          default: n_byp = 1'b0;
        endcase
      end else if (shiftDR) begin
        case (m_sel())
          1:       n_id  = (m_id >> 1) + (tdi ? 32'h8000_0000 : 32'h0);
          2:       n_usr = (m_usr >> 1) + (tdi ? 8'h80 : 8'h00);
          default: n_byp = tdi;
        endcase
      end
    end
    if (updateDR && !m_pdr && m_sel() == 2) begin
      n_udo = m_usr;
      n_upd = 1'b1;
    end
    m_irs = n_irs; m_irv = n_irv; m_byp = n_byp; m_id = n_id;
    m_usr = n_usr; m_udo = n_udo; m_upd = n_upd;
    m_pir = updateIR; m_pdr = updateDR;
  endtask

  // Let the inputs settle, then compare all DUT outputs against the model.
  task automatic step();
    #1;
    if (m_valid) begin
      chk("tdo", 32'(tdo), 32'(m_tdo()));
      chk("tdo_en", 32'(tdo_en), 32'(shiftIR | shiftDR));
      chk("ir_value", 32'(ir_value), 32'(m_irv));
      chk("user_dr_out", 32'(user_dr_out), 32'(m_udo));
      chk("user_upd", 32'(user_upd), 32'(m_upd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; tdi = 0; captureIR = 0; shiftIR = 0;
    captureDR = 0; shiftDR = 0; updateIR = 0; updateDR = 0;
  endtask

  task automatic cyc();
    step(); tick();
  endtask

  task automatic load_ir(input logic [3:0] v);
    idle(); captureIR = 1; cyc();
    for (int i = 0; i < 4; i++) begin
      idle(); shiftIR = 1; tdi = v[i]; cyc();
    end
    idle(); updateIR = 1; cyc();
    idle(); cyc();
  endtask

  initial begin
    logic [31:0] idlit;
    logic [7:0]  a5, s3c;
    int          pulses;
    idlit = 32'h1000_0001; a5 = 8'hA5; s3c = 8'h3C;
    idle(); user_dr_in = 8'h00;
    @(negedge clk);
    reset = 1; tick();
    idle(); step();
    chk("rst_ir_value", 32'(ir_value), 32'h1);
    chk("rst_user_dr_out", 32'(user_dr_out), 32'h0);
    chk("rst_user_upd", 32'(user_upd), 32'h0);
    tick();

    // IDCODE shifted out LSB first
    idle(); captureDR = 1; cyc();
    for (int i = 0; i < 32; i++) begin
      idle(); shiftDR = 1; step();
      chk("idcode_bit", 32'(tdo), 32'(idlit[i]));
      tick();
    end

    // IR load of 4'hF with a held update level
    idle(); captureIR = 1; cyc();
    for (int i = 0; i < 4; i++) begin
      idle(); shiftIR = 1; tdi = 1; step();
      chk("ir_cap_bit", 32'(tdo), (i == 0) ? 32'h1 : 32'h0);
      tick();
    end
    idle(); updateIR = 1; cyc();
    idle(); updateIR = 1; shiftIR = 1; step();
    chk("ir_after_update", 32'(ir_value), 32'hF);
    tick();
    idle(); updateIR = 1; shiftIR = 1; cyc();
    idle(); step();
    chk("ir_held_no_reload", 32'(ir_value), 32'hF);
    tick();
    idle(); captureDR = 1; cyc();
    idle(); shiftDR = 1; tdi = 1; step(); chk("byp_0", 32'(tdo), 32'h0); tick();
    idle(); shiftDR = 1; tdi = 0; step(); chk("byp_1", 32'(tdo), 32'h1); tick();

    // USER round trip
    load_ir(4'h2);
    chk("ir_user", 32'(ir_value), 32'h2);
    idle(); user_dr_in = 8'hA5; captureDR = 1; cyc();
    for (int i = 0; i < 8; i++) begin
      idle(); shiftDR = 1; tdi = s3c[i]; step();
      chk("user_out_bit", 32'(tdo), 32'(a5[i]));
      tick();
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); updateDR = (i < 3); step();
      if (user_upd) pulses++;
      tick();
    end
    chk("user_dr_out_3c", 32'(user_dr_out), 32'h3C);
    chk("user_upd_pulses", 32'(pulses), 32'd1);

    // Unassigned instruction: no update and bypass behaviour
    load_ir(4'h7);
    pulses = 0;
    idle(); updateDR = 1; step(); tick();
    idle(); step(); if (user_upd) pulses++; tick();
    chk("unassigned_no_pulse", 32'(pulses), 32'd0);
    chk("unassigned_hold", 32'(user_dr_out), 32'h3C);
    idle(); captureDR = 1; cyc();
    idle(); shiftDR = 1; tdi = 1; step(); chk("unassigned_byp0", 32'(tdo), 32'h0); tick();
    idle(); shiftDR = 1; tdi = 1; step(); chk("unassigned_byp1", 32'(tdo), 32'h1); tick();

    // Reset during USER shifting
    load_ir(4'h2);
    idle(); user_dr_in = 8'hFF; captureDR = 1; cyc();
    for (int i = 0; i < 3; i++) begin idle(); shiftDR = 1; tdi = 1; cyc(); end
    idle(); reset = 1; shiftDR = 1; tick();
    idle(); step();
    chk("midrst_ir", 32'(ir_value), 32'h1);
    chk("midrst_udo", 32'(user_dr_out), 32'h0);
    tick();

    // Capture and shift together: capture wins
    load_ir(4'h2);
    idle(); user_dr_in = 8'h01; captureDR = 1; cyc();
    idle(); user_dr_in = 8'h02; captureDR = 1; shiftDR = 1; step();
    chk("capshift_old_lsb", 32'(tdo), 32'h1);
    tick();
    idle(); shiftDR = 1; step(); chk("capshift_new0", 32'(tdo), 32'h0); tick();
    idle(); shiftDR = 1; step(); chk("capshift_new1", 32'(tdo), 32'h1); tick();

    // Randomized traffic checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      tdi        = 1'($urandom);
      captureIR  = ($urandom_range(0, 5) == 0);
      shiftIR    = ($urandom_range(0, 3) == 0);
      captureDR  = ($urandom_range(0, 4) == 0);
      shiftDR    = ($urandom_range(0, 1) == 0);
      updateIR   = ($urandom_range(0, 4) == 0);
      updateDR   = ($urandom_range(0, 3) == 0);
      user_dr_in = 8'($urandom);
      cyc();
    end

    idle(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_data_registers.md
JTAG_DATA_REGISTERS -- requirements
Module: jtag_data_registers

Interface
REQ-001 Parameter IR_W, default 4, instruction register width.
REQ-002 Parameter USER_W, default 8, user data register width.
REQ-003 Parameter IDCODE_VAL, default 32'h1000_0001, IDCODE register contents; bit 0 SHALL be 1.
REQ-004 Parameter OP_IDCODE, default 4'h1; OP_USER, default 4'h2; OP_BYPASS, default 4'hF.
REQ-005 clk  input  1  block clock; all state SHALL update on the rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tdi  input  1  serial test data in.
REQ-008 captureIR, shiftIR, captureDR, shiftDR  input  1 each  TAP phase levels.
REQ-009 updateIR, updateDR  input  1 each  TAP update levels, possibly held for several cycles.
REQ-010 user_dr_in  input  USER_W  parallel value captured into the user shift chain.
REQ-011 tdo  output  1  serial test data out.
REQ-012 tdo_en  output  1  tdo drive enable.
REQ-013 ir_value  output  IR_W  current, already updated, instruction.
REQ-014 user_dr_out  output  USER_W  updated user register.
REQ-015 user_upd  output  1  one-cycle pulse when user_dr_out is loaded.

Function
REQ-016 Registers: ir_shift (IR_W), ir_value (IR_W), byp (1), id_shift (32), usr_shift (USER_W), user_dr_out (USER_W), and upd_ir_q/upd_dr_q edge-detect flops.
REQ-017 Selected DR: ir_value==OP_IDCODE -> IDCODE; ==OP_USER -> USER; any other value, including OP_BYPASS -> BYPASS.
REQ-018 captureIR high -> ir_shift <= {IR_W-2 zeros, 2'b01} on the next edge.
REQ-019 shiftIR high -> ir_shift <= {tdi, ir_shift[IR_W-1:1]}, LSB first.
REQ-020 Rising edge of updateIR (updateIR & ~upd_ir_q) -> ir_value <= ir_shift; a held level SHALL NOT reload.
REQ-021 captureDR high loads only the selected DR: BYPASS byp<=0; IDCODE id_shift<=IDCODE_VAL; USER usr_shift<=user_dr_in.
REQ-022 shiftDR high shifts only the selected DR, tdi into MSB, LSB first; byp<=tdi for BYPASS.
REQ-023 Rising edge of updateDR with USER selected -> user_dr_out <= usr_shift and user_upd=1 for exactly one cycle; with other selections, no effect and no pulse.
REQ-024 tdo (combinational): shiftIR -> ir_shift[0]; shiftDR -> LSB of selected DR (byp, id_shift[0], usr_shift[0]); otherwise 0.
REQ-025 tdo_en = shiftIR | shiftDR.
REQ-026 Capture and shift both high on the same chain -> capture wins; IR and DR phase inputs both high -> IR actions only, DR chains hold.
REQ-027 Shift chains and ir_value SHALL hold their value when no phase input is active.
REQ-028 A change of ir_value SHALL NOT alter any DR shift contents; the new selection applies from the next cycle.
REQ-029 Shift count is unbounded; bits past register width shift out on tdo (wrap-free, no saturation).

Reset
REQ-030 reset high at a rising edge -> ir_shift=0, ir_value=OP_IDCODE, byp=0, id_shift=IDCODE_VAL, usr_shift=0, user_dr_out=0, user_upd=0, upd_ir_q=upd_dr_q=0.
REQ-031 reset has priority over every phase input; reset mid-shift discards the partial shift.
REQ-032 An update level already high when reset deasserts SHALL count as a rising edge on the first non-reset cycle.

Verification
REQ-033 Reset, captureDR 1 cycle, shiftDR 32 cycles, tdi=0 -> tdo sequence 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0 (IDCODE_VAL LSB first).
REQ-034 captureIR, shiftIR 4 cycles with tdi 1,1,1,1, updateIR held 3 cycles -> tdo 1,0,0,0; ir_value=4'hF after 1 edge only; then captureDR, shiftDR tdi 1,0 -> tdo 0,1 (bypass 1-cycle delay).
REQ-035 Load IR=4'h2, user_dr_in=8'hA5, captureDR, shiftDR 8 cycles with tdi bits of 8'h3C LSB first, updateDR -> tdo emits A5 LSB first; user_dr_out=8'h3C; user_upd high exactly 1 cycle.
REQ-036 IR=4'h7 (unassigned), updateDR pulse -> user_dr_out unchanged, user_upd stays 0, DR path behaves as bypass.
REQ-037 Assert reset after 3 of 8 USER shift cycles -> all registers at REQ-030 values; ir_value=OP_IDCODE on the next cycle.
REQ-038 captureDR and shiftDR both high with USER selected -> usr_shift=user_dr_in, no shift, tdo=old usr_shift[0].
